// File: rtl/flash_ctrl_pkg.sv
// Shared flash controller types used by the hardware seed fetch block.
package flash_ctrl_pkg;

    typedef enum logic [1:0] {
        FlashOpRead    = 2'h0,
        FlashOpProgram = 2'h1,
        FlashOpErase   = 2'h2,
        FlashOpInvalid = 2'h3
    } flash_op_e;

    typedef enum logic [1:0] {
        PhaseSeed    = 2'h0,
        PhaseRma     = 2'h1,
        PhaseNone    = 2'h2,
        PhaseInvalid = 2'h3
    } flash_lcmgr_phase_e;

    typedef enum logic [2:0] {
        StIdle = 3'h0,
        StReq  = 3'h1,
        StRead = 3'h2,
        StNext = 3'h3,
        StDone = 3'h4
    } flash_hw_seed_st_e;

    // Index counters keep at least one bit even for a single seed.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flash_hw_seed_fetch_if.sv
// Hardware request port between the seed fetch initiator (master) and the flash arbiter (slave).
interface flash_hw_seed_fetch_if #(
    parameter int unsigned BusWidth = 32
);
    import flash_ctrl_pkg::*;

    logic                  req;
    logic                  sel;
    logic                  start;
    flash_op_e             op;
    logic [11:0]           num;
    logic [31:0]           addr;
    flash_lcmgr_phase_e    phase;
    logic                  ack;
    logic                  err;
    logic                  rvalid;
    logic [BusWidth-1:0]   rdata;
    logic                  rready;

    modport master (
        output req, start, op, num, addr, phase, rready,
        input  sel, ack, err, rvalid, rdata
    );

    modport slave (
        input  req, start, op, num, addr, phase, rready,
        output sel, ack, err, rvalid, rdata
    );

endinterface

// File: rtl/flash_hw_seed_word_cnt.sv
// Per-seed read tracking: word counter, ack/error capture, completion detect and discard of surplus beats.
module flash_hw_seed_word_cnt #(
    parameter int unsigned SeedWords = 8,
    parameter int unsigned CntW      = $clog2(SeedWords + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            active_i,
    input  logic            rvalid_i,
    input  logic            ack_i,
    input  logic            err_i,
    output logic            wr_en_o,
    output logic [CntW-1:0] wr_idx_o,
    output logic            op_done_o,
    output logic            op_err_o
);

    localparam logic [CntW-1:0] FullCnt = CntW'(SeedWords);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_nxt;
    logic            ack_seen_q;
    logic            err_q;
    logic            ack_now;

    assign ack_now   = active_i & ack_i;
    assign wr_en_o   = active_i & rvalid_i & (cnt_q < FullCnt);
    assign wr_idx_o  = cnt_q;
    assign cnt_nxt   = cnt_q + CntW'(wr_en_o);
    assign op_err_o  = err_q | (ack_now & err_i);
    // Ack and the final beat may coincide, so completion looks at this cycle's values.
    assign op_done_o = active_i & (ack_seen_q | ack_now) & ((cnt_nxt == FullCnt) | op_err_o);

    // Tracking state only lives while a read is active; any other state clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            ack_seen_q <= 1'b0;
            err_q      <= 1'b0;
        end else if (!active_i) begin
            cnt_q      <= '0;
            ack_seen_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q <= cnt_nxt;
            if (ack_i) begin
                ack_seen_q <= 1'b1;
                err_q      <= err_i;
            end
        end
    end

endmodule

// File: rtl/flash_hw_seed_fetch.sv
// Hardware seed fetch initiator: arbitrates for the flash, reads NumSeeds seeds into registers.
// Optional build macro FLASH_HW_SEED_SANITY_CHK_EN rejects all-zero / all-one seeds.
//
// state  | meaning
// StIdle | waiting for init, seed state cleared
// StReq  | requesting the flash interface from the arbiter
// StRead | read issued for seed idx, collecting words
// StNext | one-cycle gap, advance to next seed
// StDone | all seeds processed, results held
module flash_hw_seed_fetch
    import flash_ctrl_pkg::*;
#(
    parameter int unsigned NumSeeds     = 2,
    parameter int unsigned SeedWords    = 8,
    parameter int unsigned BusWidth     = 32,
    parameter logic [31:0] SeedBaseAddr = 32'h0,
    parameter logic [31:0] SeedStride   = 32'h800
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       init_i,
    flash_hw_seed_fetch_if.master                      hw,
    output logic [NumSeeds-1:0][SeedWords*BusWidth-1:0] seed_o,
    output logic [NumSeeds-1:0]                        seed_valid_o,
    output logic                                       busy_o,
    output logic                                       done_o
);

    localparam int unsigned IdxW    = idx_width(NumSeeds);
    localparam int unsigned CntW    = $clog2(SeedWords + 1);
    localparam int unsigned SeedW   = SeedWords * BusWidth;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumSeeds - 1);

    flash_hw_seed_st_e                  st_q;
    logic [IdxW-1:0]                    idx_q;
    logic [NumSeeds-1:0][SeedW-1:0]     seed_q;
    logic [NumSeeds-1:0]                seed_valid_q;
    logic                               req_q;
    logic                               start_q;
    logic                               rready_q;
    flash_lcmgr_phase_e                 phase_q;
    logic                               busy_q;
    logic                               done_q;

    logic                               wr_en;
    logic [CntW-1:0]                    wr_idx;
    logic                               op_done;
    logic                               op_err;
    logic                               seed_ok;

    flash_hw_seed_word_cnt #(
        .SeedWords (SeedWords),
        .CntW      (CntW)
    ) u_word_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .active_i  (st_q == StRead),
        .rvalid_i  (hw.rvalid),
        .ack_i     (hw.ack),
        .err_i     (hw.err),
        .wr_en_o   (wr_en),
        .wr_idx_o  (wr_idx),
        .op_done_o (op_done),
        .op_err_o  (op_err)
    );

`ifdef FLASH_HW_SEED_SANITY_CHK_EN
    logic [SeedW-1:0] row_nxt;

    // Judge the seed as it will look after this cycle's write.
    always_comb begin
        row_nxt = seed_q[idx_q];
        if (wr_en) row_nxt[int'(wr_idx)*BusWidth +: BusWidth] = hw.rdata;
    end

    assign seed_ok = !op_err && (row_nxt != '0) && (row_nxt != '1);
`else
    assign seed_ok = !op_err;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q         <= StIdle;
            idx_q        <= '0;
            seed_q       <= '0;
            seed_valid_q <= '0;
            req_q        <= 1'b0;
            start_q      <= 1'b0;
            rready_q     <= 1'b0;
            phase_q      <= PhaseInvalid;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (wr_en) seed_q[idx_q][int'(wr_idx)*BusWidth +: BusWidth] <= hw.rdata;
            unique case (st_q)
                StIdle: begin
                    seed_valid_q <= '0;
                    idx_q        <= '0;
                    if (init_i) begin
                        st_q    <= StReq;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        phase_q <= PhaseSeed;
                    end
                end
                StReq: begin
                    if (hw.sel) begin
                        st_q     <= StRead;
                        start_q  <= 1'b1;
                        rready_q <= 1'b1;
                    end
                end
                StRead: begin
                    if (hw.ack) start_q <= 1'b0;
                    if (op_done) begin
                        seed_valid_q[idx_q] <= seed_ok;
                        start_q             <= 1'b0;
                        rready_q            <= 1'b0;
                        if (idx_q == LastIdx) begin
                            st_q    <= StDone;
                            req_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            phase_q <= PhaseInvalid;
                        end else begin
                            st_q <= StNext;
                        end
                    end
                end
                StNext: begin
                    idx_q    <= idx_q + 1'b1;
                    st_q     <= StRead;
                    start_q  <= 1'b1;
                    rready_q <= 1'b1;
                end
                StDone: begin
                    if (init_i) begin
                        st_q         <= StReq;
                        seed_valid_q <= '0;
                        idx_q        <= '0;
                        req_q        <= 1'b1;
                        busy_q       <= 1'b1;
                        phase_q      <= PhaseSeed;
                    end
                end
                default: st_q <= StIdle;
            endcase
        end
    end

    assign hw.req       = req_q;
    assign hw.start     = start_q;
    assign hw.op        = FlashOpRead;
    assign hw.num       = 12'(SeedWords - 1);
    assign hw.addr      = SeedBaseAddr + (32'(idx_q) * SeedStride);
    assign hw.phase     = phase_q;
    assign hw.rready    = rready_q;
    assign seed_o       = seed_q;
    assign seed_valid_o = seed_valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_flash_hw_seed_fetch.sv
// Directed self-checking bench for flash_hw_seed_fetch (default 2 seeds x 8 words x 32 bits).
module tb_flash_hw_seed_fetch;
    import flash_ctrl_pkg::*;

    localparam int NumSeeds  = 2;
    localparam int SeedWords = 8;
    localparam int BusWidth  = 32;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    logic init_i = 1'b0;
    logic [NumSeeds-1:0][SeedWords*BusWidth-1:0] seed_o;
    logic [NumSeeds-1:0] seed_valid_o;
    logic busy_o;
    logic done_o;

    int checks = 0;
    int errors = 0;

    flash_hw_seed_fetch_if #(.BusWidth(BusWidth)) hw_if ();

    flash_hw_seed_fetch #(
        .NumSeeds     (NumSeeds),
        .SeedWords    (SeedWords),
        .BusWidth     (BusWidth),
        .SeedBaseAddr (32'h0),
        .SeedStride   (32'h800)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .init_i       (init_i),
        .hw           (hw_if),
        .seed_o       (seed_o),
        .seed_valid_o (seed_valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cyc(input logic v, input logic [31:0] d, input logic a, input logic e);
        hw_if.rvalid = v;
        hw_if.rdata  = d;
        hw_if.ack    = a;
        hw_if.err    = e;
        tick();
        hw_if.rvalid = 1'b0;
        hw_if.ack    = 1'b0;
        hw_if.err    = 1'b0;
    endtask

    task automatic fetch_start(input int gap);
        hw_if.sel = 1'b0;
        init_i = 1'b1;
        tick();
        init_i = 1'b0;
        repeat (gap) tick();
        hw_if.sel = 1'b1;
        tick();
    endtask

    task automatic beat_run(input logic [31:0] base);
        for (int k = 0; k < SeedWords; k++) cyc(1'b1, base + 32'(k), k == SeedWords - 1, 1'b0);
    endtask

    function automatic logic [SeedWords*BusWidth-1:0] ramp(input logic [31:0] base, input logic [31:0] step);
        logic [SeedWords*BusWidth-1:0] r;
        r = '0;
        for (int k = 0; k < SeedWords; k++) r[k*BusWidth +: BusWidth] = base + 32'(k) * step;
        return r;
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) tick();
        checks++; if (hw_if.req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", hw_if.req); end
        checks++; if (hw_if.start !== 1'b0) begin errors++; $display("FAIL rst_start got %0b exp 0", hw_if.start); end
        checks++; if (hw_if.rready !== 1'b0) begin errors++; $display("FAIL rst_rready got %0b exp 0", hw_if.rready); end
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL rst_busy_done got %0b%0b exp 00", busy_o, done_o); end
        checks++; if (seed_o !== '0 || seed_valid_o !== 2'b00) begin errors++; $display("FAIL rst_seed got valid %b exp 00 / seed nonzero", seed_valid_o); end
        checks++; if (hw_if.phase !== PhaseInvalid) begin errors++; $display("FAIL rst_phase got %0d exp %0d", hw_if.phase, PhaseInvalid); end
        checks++; if (hw_if.op !== FlashOpRead) begin errors++; $display("FAIL rst_op got %0d exp %0d", hw_if.op, FlashOpRead); end
        checks++; if (hw_if.num !== 12'd7) begin errors++; $display("FAIL rst_num got %0d exp 7", hw_if.num); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        init_i = 1'b1;
        tick();
        init_i = 1'b0;
        checks++; if (hw_if.req !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL basic_req got req %0b busy %0b exp 1 1", hw_if.req, busy_o); end
        checks++; if (hw_if.start !== 1'b0) begin errors++; $display("FAIL basic_nostart got %0b exp 0", hw_if.start); end
        repeat (2) tick();
        hw_if.sel = 1'b1;
        tick();
        checks++; if (hw_if.start !== 1'b1 || hw_if.rready !== 1'b1) begin errors++; $display("FAIL basic_start got start %0b rready %0b exp 1 1", hw_if.start, hw_if.rready); end
        checks++; if (hw_if.addr !== 32'h0) begin errors++; $display("FAIL basic_addr0 got %h exp 00000000", hw_if.addr); end
        checks++; if (hw_if.phase !== PhaseSeed) begin errors++; $display("FAIL basic_phase got %0d exp %0d", hw_if.phase, PhaseSeed); end
        beat_run(32'h1000);
        checks++; if (seed_valid_o !== 2'b01 || hw_if.start !== 1'b0) begin errors++; $display("FAIL basic_seed0_done got valid %b start %0b exp 01 0", seed_valid_o, hw_if.start); end
        tick();
        checks++; if (hw_if.addr !== 32'h800 || hw_if.start !== 1'b1) begin errors++; $display("FAIL basic_addr1 got %h start %0b exp 00000800 1", hw_if.addr, hw_if.start); end
        beat_run(32'h1100);
        checks++; if (done_o !== 1'b1 || hw_if.req !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL basic_done got done %0b req %0b busy %0b exp 1 0 0", done_o, hw_if.req, busy_o); end
        checks++; if (seed_valid_o !== 2'b11) begin errors++; $display("FAIL basic_valid got %b exp 11", seed_valid_o); end
        checks++; if (seed_o[0] !== ramp(32'h1000, 32'h1)) begin errors++; $display("FAIL basic_seed0 got %h exp %h", seed_o[0], ramp(32'h1000, 32'h1)); end
        checks++; if (seed_o[1] !== ramp(32'h1100, 32'h1)) begin errors++; $display("FAIL basic_seed1 got %h exp %h", seed_o[1], ramp(32'h1100, 32'h1)); end
        tick();
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %0b exp 0", done_o); end
        hw_if.sel = 1'b0;
    endtask

    task automatic test_error();
        int starts;
        fetch_start(1);
        beat_run(32'h2000);
        tick();
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'h2100 + 32'(k), 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1);
        checks++; if (seed_valid_o !== 2'b01) begin errors++; $display("FAIL err_valid got %b exp 01", seed_valid_o); end
        checks++; if (done_o !== 1'b1 || hw_if.req !== 1'b0) begin errors++; $display("FAIL err_done got done %0b req %0b exp 1 0", done_o, hw_if.req); end
        starts = 0;
        for (int k = 0; k < 4; k++) begin
            if (hw_if.start) starts++;
            cyc(1'b1, 32'hBAD0 + 32'(k), 1'b0, 1'b0);
        end
        checks++; if (starts !== 0) begin errors++; $display("FAIL err_no_restart got %0d start cycles exp 0", starts); end
        checks++; if (seed_o[1][31:0] !== 32'h2100) begin errors++; $display("FAIL err_word0 got %h exp 00002100", seed_o[1][31:0]); end
        hw_if.sel = 1'b0;
    endtask

    task automatic test_early_ack();
        fetch_start(0);
        for (int k = 0; k < 5; k++) cyc(1'b1, 32'h3000 + 32'(k), 1'b0, 1'b0);
        cyc(1'b1, 32'h3005, 1'b1, 1'b0);
        checks++; if (hw_if.start !== 1'b0 || hw_if.rready !== 1'b1) begin errors++; $display("FAIL early_start got start %0b rready %0b exp 0 1", hw_if.start, hw_if.rready); end
        checks++; if (seed_valid_o !== 2'b00 || busy_o !== 1'b1) begin errors++; $display("FAIL early_wait got valid %b busy %0b exp 00 1", seed_valid_o, busy_o); end
        cyc(1'b1, 32'h3006, 1'b0, 1'b0);
        checks++; if (seed_valid_o !== 2'b00 || hw_if.start !== 1'b0) begin errors++; $display("FAIL early_beat7 got valid %b start %0b exp 00 0", seed_valid_o, hw_if.start); end
        cyc(1'b1, 32'h3007, 1'b0, 1'b0);
        checks++; if (seed_valid_o !== 2'b01) begin errors++; $display("FAIL early_complete got %b exp 01", seed_valid_o); end
        checks++; if (seed_o[0] !== ramp(32'h3000, 32'h1)) begin errors++; $display("FAIL early_seed0 got %h exp %h", seed_o[0], ramp(32'h3000, 32'h1)); end
        tick();
        for (int k = 0; k < SeedWords; k++) cyc(1'b1, 32'h3100 + 32'(k), 1'b0, 1'b0);
        checks++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin errors++; $display("FAIL full_noack got busy %0b done %0b exp 1 0", busy_o, done_o); end
        cyc(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        checks++; if (done_o !== 1'b1 || seed_valid_o !== 2'b11) begin errors++; $display("FAIL discard_done got done %0b valid %b exp 1 11", done_o, seed_valid_o); end
        checks++; if (seed_o[1] !== ramp(32'h3100, 32'h1)) begin errors++; $display("FAIL discard_seed1 got %h exp %h", seed_o[1], ramp(32'h3100, 32'h1)); end
        hw_if.sel = 1'b0;
    endtask

    task automatic test_gaps();
        int rr_low;
        fetch_start(2);
        rr_low = 0;
        for (int c = 0; c < 15; c++) begin
            if (hw_if.rready !== 1'b1) rr_low++;
            if (c % 2 == 0) cyc(1'b1, 32'hC0DE0000 + 32'(c / 2) * 32'h3, c == 14, 1'b0);
            else cyc(1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
        end
        checks++; if (rr_low !== 0) begin errors++; $display("FAIL gaps_rready got %0d low cycles exp 0", rr_low); end
        checks++; if (seed_valid_o !== 2'b01) begin errors++; $display("FAIL gaps_valid got %b exp 01", seed_valid_o); end
        checks++; if (seed_o[0] !== ramp(32'hC0DE0000, 32'h3)) begin errors++; $display("FAIL gaps_seed0 got %h exp %h", seed_o[0], ramp(32'hC0DE0000, 32'h3)); end
        tick();
        beat_run(32'h4100);
        checks++; if (done_o !== 1'b1 || seed_valid_o !== 2'b11) begin errors++; $display("FAIL gaps_done got done %0b valid %b exp 1 11", done_o, seed_valid_o); end
        hw_if.sel = 1'b0;
    endtask

    task automatic test_reset_reinit();
        fetch_start(0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'h5000 + 32'(k), 1'b0, 1'b0);
        #2 rst_ni = 1'b0;
        hw_if.sel = 1'b0;
        #1;
        checks++; if (hw_if.req !== 1'b0 || hw_if.start !== 1'b0 || hw_if.rready !== 1'b0) begin errors++; $display("FAIL arst_hw got req %0b start %0b rready %0b exp 0 0 0", hw_if.req, hw_if.start, hw_if.rready); end
        checks++; if (seed_o !== '0 || seed_valid_o !== 2'b00 || busy_o !== 1'b0) begin errors++; $display("FAIL arst_seed got valid %b busy %0b exp 00 0 / seed nonzero", seed_valid_o, busy_o); end
        checks++; if (hw_if.phase !== PhaseInvalid) begin errors++; $display("FAIL arst_phase got %0d exp %0d", hw_if.phase, PhaseInvalid); end
        tick();
        rst_ni = 1'b1;
        tick();
        init_i = 1'b1;
        tick();
        hw_if.sel = 1'b1;
        tick();
        checks++; if (hw_if.start !== 1'b1 || hw_if.addr !== 32'h0) begin errors++; $display("FAIL busy_init_req got start %0b addr %h exp 1 00000000", hw_if.start, hw_if.addr); end
        cyc(1'b1, 32'h5100, 1'b0, 1'b0);
        init_i = 1'b0;
        checks++; if (hw_if.start !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL busy_init_read got start %0b busy %0b exp 1 1", hw_if.start, busy_o); end
        for (int k = 1; k < SeedWords; k++) cyc(1'b1, 32'h5100 + 32'(k), k == SeedWords - 1, 1'b0);
        checks++; if (seed_valid_o !== 2'b01 || seed_o[0] !== ramp(32'h5100, 32'h1)) begin errors++; $display("FAIL busy_init_seed0 got valid %b seed %h", seed_valid_o, seed_o[0]); end
        tick();
        beat_run(32'h5200);
        checks++; if (done_o !== 1'b1 || seed_valid_o !== 2'b11) begin errors++; $display("FAIL pre_reinit got done %0b valid %b exp 1 11", done_o, seed_valid_o); end
        init_i = 1'b1;
        tick();
        init_i = 1'b0;
        checks++; if (seed_valid_o !== 2'b00 || hw_if.req !== 1'b1) begin errors++; $display("FAIL reinit_clear got valid %b req %0b exp 00 1", seed_valid_o, hw_if.req); end
        tick();
        for (int k = 0; k < SeedWords - 1; k++) cyc(1'b1, 32'h5300 + 32'(k), 1'b0, 1'b0);
        checks++; if (seed_valid_o !== 2'b00) begin errors++; $display("FAIL reinit_hold got %b exp 00", seed_valid_o); end
        cyc(1'b1, 32'h5307, 1'b1, 1'b0);
        checks++; if (seed_valid_o !== 2'b01 || seed_o[0] !== ramp(32'h5300, 32'h1)) begin errors++; $display("FAIL reinit_seed0 got valid %b seed %h", seed_valid_o, seed_o[0]); end
        tick();
        beat_run(32'h5400);
        checks++; if (done_o !== 1'b1 || seed_valid_o !== 2'b11) begin errors++; $display("FAIL reinit_done got done %0b valid %b exp 1 11", done_o, seed_valid_o); end
        hw_if.sel = 1'b0;
    endtask

    task automatic test_sanity();
        logic exp_v0;
`ifdef FLASH_HW_SEED_SANITY_CHK_EN
        exp_v0 = 1'b0;
`else
        exp_v0 = 1'b1;
`endif
        fetch_start(0);
        for (int k = 0; k < SeedWords; k++) cyc(1'b1, 32'hFFFFFFFF, k == SeedWords - 1, 1'b0);
        checks++; if (seed_valid_o[0] !== exp_v0) begin errors++; $display("FAIL sanity_ones got %0b exp %0b", seed_valid_o[0], exp_v0); end
        tick();
        beat_run(32'h6100);
        checks++; if (seed_valid_o[1] !== 1'b1 || done_o !== 1'b1) begin errors++; $display("FAIL sanity_seed1 got valid %0b done %0b exp 1 1", seed_valid_o[1], done_o); end
        hw_if.sel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        hw_if.sel    = 1'b0;
        hw_if.ack    = 1'b0;
        hw_if.err    = 1'b0;
        hw_if.rvalid = 1'b0;
        hw_if.rdata  = '0;
        test_reset();
        test_basic();
        test_error();
        test_early_ack();
        test_gaps();
        test_reset_reinit();
        test_sanity();
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
